// File: rtl/xnor_prbs_engine_if.sv
// Signal bundle between a PRBS pattern user (master) and xnor_prbs_engine (slave).
// clk and rst_n stay as plain ports on the engine.
interface xnor_prbs_engine_if #(
    parameter int CNT_W = 16
);
    logic             gen_en;
    logic             gen_inj_err;
    logic             gen_bit;
    logic             chk_valid;
    logic             chk_bit;
    logic             err_clr;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;

    modport master (
        output gen_en, gen_inj_err, chk_valid, chk_bit, err_clr,
        input  gen_bit, locked, err_pulse, err_count
    );

    modport slave (
        input  gen_en, gen_inj_err, chk_valid, chk_bit, err_clr,
        output gen_bit, locked, err_pulse, err_count
    );
endinterface

// File: rtl/xnor_prbs_engine.sv
// XNOR-feedback LFSR PRBS generator plus an independent self-synchronising checker
// (SEARCH -> VERIFY -> LOCKED) with a flywheel predictor and saturating error count.
module xnor_prbs_engine #(
    parameter int               WIDTH    = 7,
    parameter logic [WIDTH-1:0] TAPS     = 7'h60,
    parameter int               LOCK_CNT = 16,
    parameter int               ERR_LOSS = 4,
    parameter int               CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    xnor_prbs_engine_if.slave prbs_if
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_fsm_e;

    localparam int               LOAD_W  = $clog2(WIDTH + 1);
    localparam int               MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int               MISS_W  = $clog2(ERR_LOSS + 1);
    localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

    // All-ones is the lock-up state of XNOR feedback; all-zeros is a legal state.
    function automatic logic fb(input logic [WIDTH-1:0] s);
        return ~(^(s & TAPS));
    endfunction

    // ---------------- generator ----------------
    logic [WIDTH-1:0] gen_state_q;
    logic             gen_bit_q;
    logic             gen_fb;

    assign gen_fb = fb(gen_state_q);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would chain the shift within one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gen_state_q <= '0;
            gen_bit_q   <= 1'b0;
        end else if (prbs_if.gen_en) begin
            gen_state_q <= {gen_state_q[WIDTH-2:0], gen_fb};
            gen_bit_q   <= gen_fb ^ prbs_if.gen_inj_err;
        end
    end

    // ---------------- checker ----------------
    chk_fsm_e         fsm_q,       fsm_d;
    logic [WIDTH-1:0] chk_state_q, chk_state_d;
    logic [LOAD_W-1:0]  load_cnt_q,  load_cnt_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]  miss_cnt_q,  miss_cnt_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             err_pulse_q;
    logic             err_hit;

    logic [WIDTH-1:0] load_shift;
    logic [WIDTH-1:0] fly_shift;
    logic             pred;
    logic             match;

    assign pred       = fb(chk_state_q);
    assign match      = ~(pred ^ prbs_if.chk_bit);
    assign load_shift = {chk_state_q[WIDTH-2:0], prbs_if.chk_bit};
    assign fly_shift  = {chk_state_q[WIDTH-2:0], pred};

    // NOTE: every signal written below gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        fsm_d       = fsm_q;
        chk_state_d = chk_state_q;
        load_cnt_d  = load_cnt_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_hit     = 1'b0;

        if (prbs_if.chk_valid) begin
            case (fsm_q)
                SEARCH: begin
                    chk_state_d = load_shift;
                    if (&load_shift) begin
                        load_cnt_d = '0;
                    end else if (load_cnt_q == LOAD_W'(WIDTH - 1)) begin
                        fsm_d       = VERIFY;
                        load_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else begin
                        load_cnt_d = load_cnt_q + LOAD_W'(1);
                    end
                end
                VERIFY: begin
                    chk_state_d = fly_shift;
                    if (!match) begin
                        fsm_d       = SEARCH;
                        load_cnt_d  = '0;
                        match_cnt_d = '0;
                    end else if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
                        fsm_d       = LOCKED;
                        match_cnt_d = '0;
                        miss_cnt_d  = '0;
                    end else begin
                        match_cnt_d = match_cnt_q + MATCH_W'(1);
                    end
                end
                LOCKED: begin
                    chk_state_d = fly_shift;
                    if (match) begin
                        miss_cnt_d = '0;
                    end else begin
                        err_hit = 1'b1;
                        if (miss_cnt_q == MISS_W'(ERR_LOSS - 1)) begin
                            fsm_d      = SEARCH;
                            load_cnt_d = '0;
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + MISS_W'(1);
                        end
                    end
                end
                default: fsm_d = SEARCH;
            endcase
        end

        // A clear coinciding with a counted mismatch leaves exactly that one error.
        err_count_d = err_count_q;
        if (prbs_if.err_clr) begin
            err_count_d = CNT_W'(err_hit);
        end else if (err_hit && err_count_q != ERR_MAX) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= SEARCH;
            chk_state_q <= '0;
            load_cnt_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            chk_state_q <= chk_state_d;
            load_cnt_q  <= load_cnt_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_hit;
        end
    end

    assign prbs_if.gen_bit   = gen_bit_q;
    assign prbs_if.locked    = (fsm_q == LOCKED);
    assign prbs_if.err_pulse = err_pulse_q;
    assign prbs_if.err_count = err_count_q;

endmodule

// File: doc/xnor_prbs_engine.md
Name: xnor_prbs_engine

Overview:
Parametrised PRBS generator and self-synchronising checker built on an XNOR-feedback LFSR, with each received bit compared by XNOR. It is the sequential successor to the team's single XNOR gate, used to produce and check link/BIST test patterns. The generator and checker share no state, so the generator output can be looped back to the checker or driven across a link.

Parameters:
WIDTH, 7, LFSR length in bits; legal range 3..32.
TAPS, 7'h60, tap mask with bit i meaning tap on state[i]. The default is x^7+x^6+1, period 127.
LOCK_CNT, 16, consecutive matches required in VERIFY to declare lock; at least 1.
ERR_LOSS, 4, consecutive mismatches in LOCKED that force re-search; at least 1.
CNT_W, 16, err_count width.

Ports:
clk  input  1  rising-edge clock, sole clock
rst_n  input  1  synchronous, active-low reset
gen_en  input  1  advance the generator one bit
gen_inj_err  input  1  invert gen_bit for this step; sampled only when gen_en=1
gen_bit  output  1  registered PRBS output bit
chk_valid  input  1  chk_bit is valid this cycle
chk_bit  input  1  received serial bit
err_clr  input  1  clear err_count
locked  output  1  checker is in LOCKED
err_pulse  output  1  one-cycle pulse per mismatch counted while LOCKED
err_count  output  CNT_W  saturating mismatch count while LOCKED

Behaviour:
- Reset is synchronous and active-low: clk with rst_n=0 sets the following.
  - gen_state=0, gen_bit=0.
  - chk_state=0, FSM=SEARCH, all internal counters=0.
  - locked=0, err_pulse=0, err_count=0.
- Feedback function: fb(s) = ~(^(s & TAPS)), the XNOR reduction of the tapped bits.
  - The all-ones state is the lock-up state.
  - The all-zeros state is legal.
- Generator, on a cycle with gen_en=1:
  - gen_state <= {gen_state[WIDTH-2:0], fb(gen_state)}.
  - gen_bit <= fb(gen_state) ^ gen_inj_err.
  - gen_en=0 holds both.
  - Latency is one cycle from gen_en to the new gen_bit.
  - Error injection never alters gen_state.
- Checker: acts only on cycles with chk_valid=1; otherwise all state holds and err_pulse=0.
- SEARCH:
  - chk_state <= {chk_state[WIDTH-2:0], chk_bit}; load_cnt++.
  - After the WIDTH-th bit, go to VERIFY.
  - Exception: if the resulting chk_state is all ones, stay in SEARCH with load_cnt=0.
- VERIFY:
  - pred = fb(chk_state); match = ~(pred ^ chk_bit).
  - chk_state shifts in pred (flywheel), not chk_bit.
  - On match, match_cnt++. Reaching LOCK_CNT goes to LOCKED, and locked=1 from the next cycle.
  - On mismatch, go to SEARCH and clear load_cnt and match_cnt.
  - No errors are counted in VERIFY.
- LOCKED:
  - Same prediction and flywheel as VERIFY.
  - On mismatch:
    - err_pulse=1 on the next cycle.
    - err_count++, saturating at 2^CNT_W-1.
    - miss_cnt++. Reaching ERR_LOSS goes to SEARCH, and locked=0 from the next cycle.
  - On match, miss_cnt=0.
- err_clr:
  - err_clr=1 sets err_count=0.
  - If err_clr and a counted mismatch occur in the same cycle, err_count=1.
  - err_clr does not affect the FSM or err_pulse.
- Dropping rst_n mid-sequence returns to the reset values on the next edge, regardless of state.
- Gaps in chk_valid are transparent: the sequence resumes from where it stopped.

Test Plan:
1. Reset, then hold gen_en=1 for 7 cycles -> gen_bit = 1,1,1,1,1,1,0. Continue to cycle 127 -> gen_state returns to 0; period is 127.
2. Loop back gen_bit into chk_bit with chk_valid delayed 1 cycle -> locked rises after 7 load bits + 16 matches. err_count stays 0 over 1000 bits.
3. While locked, pulse gen_inj_err once -> exactly one err_pulse and err_count=1; locked stays 1. The following bits match, since the flywheel does not corrupt prediction.
4. While locked, inject 4 consecutive errors -> err_count=4, locked falls after the 4th. The checker relocks 7+16 valid bits later, with err_count still 4.
5. Drive chk_bit constant 1 -> locked never asserts and the FSM stays in SEARCH. Drive random data -> locked stays 0.
6. Assert err_clr on the same cycle as a counted mismatch -> err_count=1. Assert rst_n=0 while locked -> locked=0, err_count=0 next cycle. With CNT_W=2, 5 errors -> err_count=3.
